// File: rtl/exec_ctrl_pkg.sv
// Shared encodings for the execution controller: FSM states, host command
// opcodes and halt causes.
package exec_ctrl_pkg;

  localparam logic [1:0] ST_HALTED_ENC = 2'b00;
  localparam logic [1:0] ST_RUN_ENC    = 2'b01;
  localparam logic [1:0] ST_STEP_ENC   = 2'b10;

  localparam logic [1:0] CMD_HALT_ENC    = 2'b00;
  localparam logic [1:0] CMD_RUN_ENC     = 2'b01;
  localparam logic [1:0] CMD_STEP_N_ENC  = 2'b10;
  localparam logic [1:0] CMD_CLR_CNT_ENC = 2'b11;

  localparam logic [1:0] HC_RESET_ENC      = 2'b00;
  localparam logic [1:0] HC_HOST_ENC       = 2'b01;
  localparam logic [1:0] HC_BREAKPOINT_ENC = 2'b10;
  localparam logic [1:0] HC_HALT_INSTR_ENC = 2'b11;

  typedef enum logic [1:0] {
    S_HALTED = ST_HALTED_ENC,
    S_RUN    = ST_RUN_ENC,
    S_STEP   = ST_STEP_ENC
  } exec_state_t;

  typedef enum logic [1:0] {
    C_HALT    = CMD_HALT_ENC,
    C_RUN     = CMD_RUN_ENC,
    C_STEP_N  = CMD_STEP_N_ENC,
    C_CLR_CNT = CMD_CLR_CNT_ENC
  } exec_cmd_t;

  typedef enum logic [1:0] {
    HC_RESET      = HC_RESET_ENC,
    HC_HOST       = HC_HOST_ENC,
    HC_BREAKPOINT = HC_BREAKPOINT_ENC,
    HC_HALT_INSTR = HC_HALT_INSTR_ENC
  } halt_cause_t;

endpackage

// File: rtl/exec_retire_cnt.sv
// Retired-instruction counter: wraps modulo 2^CNT_W, synchronous clear has
// priority over a simultaneous increment.
module exec_retire_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count commits; clear wins so CLR_CNT always leaves the counter at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/exec_step_ctrl.sv
// Execution controller for the single-cycle datapath. commit_en gates PC,
// register-file and data-memory writes; host commands run, halt or step the
// core, and breakpoints / halt instructions stop it before execution.
//
// Command handshake: cmd_valid is a one-cycle strobe with no ready/backpressure.
// Every command presented with cmd_valid high is consumed at that rising edge;
// a command illegal in the current state is dropped and cmd_err pulses for
// one cycle after that edge.
module exec_step_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int CNT_W    = 32,
  parameter int NSTEP_W  = 16,
  parameter int AUTO_RUN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  input  logic [NSTEP_W-1:0] cmd_count,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic [PC_W-1:0]    pc,
  input  logic               halt_instr,
  output logic               commit_en,
  output logic [1:0]         state,
  output logic               halted,
  output logic [1:0]         halt_cause,
  output logic               cmd_err,
  output logic [CNT_W-1:0]   retired
);

  localparam exec_state_t RST_STATE  = (AUTO_RUN != 0) ? S_RUN : S_HALTED;
  localparam logic        RST_HALTED = (AUTO_RUN == 0);

  exec_state_t        st;
  halt_cause_t        cause;
  logic [NSTEP_W-1:0] remaining;
  logic               bp_skip;

  exec_cmd_t   op;
  logic        running;
  logic        bp_hit;
  logic        host_halt;
  logic        stop_any;
  halt_cause_t stop_cause;
  logic        cmd_bad;
  logic        cnt_clr;

  assign op        = exec_cmd_t'(cmd_op);
  assign running   = (st == S_RUN) || (st == S_STEP);
  assign bp_hit    = bp_en && (pc == bp_addr) && !bp_skip;
  assign host_halt = cmd_valid && (op == C_HALT);
  assign stop_any  = bp_hit || halt_instr || host_halt;
  // Masked by rst so nothing retires while reset is held, even in AUTO_RUN.
  assign commit_en = running && !stop_any && !rst;
  assign cnt_clr   = cmd_valid && (op == C_CLR_CNT);

  assign state      = st;
  assign halt_cause = cause;

  // Stop priority: breakpoint, then halt instruction, then host HALT.
  always_comb begin
    stop_cause = HC_HOST;
    if (bp_hit) begin
      stop_cause = HC_BREAKPOINT;
    end else if (halt_instr) begin
      stop_cause = HC_HALT_INSTR;
    end
  end

  // Decide whether the presented command is illegal in the current state.
  always_comb begin
    cmd_bad = 1'b0;
    if (cmd_valid) begin
      case (st)
        S_HALTED: cmd_bad = (op == C_STEP_N) && (cmd_count == '0);
        S_RUN:    cmd_bad = (op == C_STEP_N);
        S_STEP:   cmd_bad = (op == C_RUN) || (op == C_STEP_N);
        default:  cmd_bad = 1'b0;
      endcase
    end
  end

  // Control FSM: run/step/halt transitions, step budget and breakpoint skip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= RST_STATE;
      halted    <= RST_HALTED;
      cause     <= HC_RESET;
      remaining <= '0;
      bp_skip   <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_err <= cmd_bad;
      case (st)
        S_HALTED: begin
          if (cmd_valid && op == C_RUN) begin
            st      <= S_RUN;
            halted  <= 1'b0;
            bp_skip <= 1'b1;
          end else if (cmd_valid && op == C_STEP_N && cmd_count != '0) begin
            st        <= S_STEP;
            halted    <= 1'b0;
            remaining <= cmd_count;
            bp_skip   <= 1'b1;
          end
        end
        S_RUN, S_STEP: begin
          // The skip only covers the first running cycle after a resume.
          bp_skip <= 1'b0;
          if (stop_any) begin
            st        <= S_HALTED;
            halted    <= 1'b1;
            cause     <= stop_cause;
            remaining <= '0;
          end else if (st == S_STEP) begin
            remaining <= remaining - NSTEP_W'(1);
            if (remaining == NSTEP_W'(1)) begin
              st     <= S_HALTED;
              halted <= 1'b1;
              cause  <= HC_HOST;
            end
          end
        end
        default: begin
          st        <= S_HALTED;
          halted    <= 1'b1;
          remaining <= '0;
          bp_skip   <= 1'b0;
        end
      endcase
    end
  end

  exec_retire_cnt #(
    .CNT_W (CNT_W)
  ) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (commit_en),
    .count (retired)
  );

endmodule

// File: doc/exec_step_ctrl.md
Name: exec_step_ctrl

Overview:
Execution controller for the single-cycle datapath (Step_Datapath). It gates instruction commit through commit_en, which is wired to the PC, register-file and data-memory write enables. Host commands provide run, halt and N-step execution; it also handles PC breakpoints, halt-instruction detection and a retired-instruction counter. It sits between the top level/debug host and Step_Datapath.

Parameters:
PC_W, 32, datapath PC width
CNT_W, 32, retired-instruction counter width
NSTEP_W, 16, width of the step-count command field
AUTO_RUN, 1, 1: leave reset in RUN (free-running bring-up); 0: leave reset in HALTED

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  host command strobe, one command per cycle
cmd_op  in  2  00 HALT, 01 RUN, 10 STEP_N, 11 CLR_CNT
cmd_count  in  NSTEP_W  instruction count for STEP_N
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
pc  in  PC_W  current datapath PC
halt_instr  in  1  decoder flag: current instruction is HALT/EBREAK
commit_en  out  1  current instruction retires at the next rising edge
state  out  2  00 HALTED, 01 RUN, 10 STEP
halted  out  1  state == HALTED
halt_cause  out  2  00 RESET, 01 HOST, 10 BREAKPOINT, 11 HALT_INSTR
cmd_err  out  1  one-cycle pulse: command illegal in current state, ignored
retired  out  CNT_W  count of committed instructions

Behaviour:
- Reset (async, immediate, also mid-operation):
  - state = RUN if AUTO_RUN else HALTED; halted = !AUTO_RUN; halt_cause = RESET.
  - retired = 0, remaining = 0, bp_skip = 0, cmd_err = 0.
  - commit_en = 0 while rst is high.
- Combinational terms:
  - running = state is RUN or STEP.
  - bp_hit = bp_en and pc == bp_addr and !bp_skip.
  - host_halt = cmd_valid and cmd_op == HALT.
  - commit_en = running and !bp_hit and !halt_instr and !host_halt.
- Stop priority in a running cycle: BREAKPOINT > HALT_INSTR > HOST.
  - Any stop term sends state to HALTED at the edge with the matching cause; remaining is cleared.
  - Breakpoint and halt-instruction stop before execution: no commit, PC unchanged.
- HALTED:
  - RUN: go to RUN, set bp_skip.
  - STEP_N with cmd_count > 0: load remaining = cmd_count, go to STEP, set bp_skip.
  - STEP_N with cmd_count == 0: ignored, cmd_err pulses.
  - HALT: no-op, no error; halt_cause unchanged.
- RUN:
  - HALT: go to HALTED, cause HOST, no commit that cycle.
  - RUN: no-op.
  - STEP_N: ignored, cmd_err pulses.
- STEP:
  - Each commit decrements remaining.
  - A commit with remaining == 1: go to HALTED, cause HOST. STEP_N of 1 therefore executes exactly one instruction.
  - HALT: same as in RUN. RUN or STEP_N: ignored, cmd_err pulses.
- bp_skip: cleared after the first running cycle. This lets execution resume from a breakpoint PC. It does not mask halt_instr.
- Halt-instruction stop is sticky: a RUN with PC still on the halt instruction re-halts on the next cycle, cause HALT_INSTR.
- retired: +1 on each commit, wraps modulo 2^CNT_W.
  - CLR_CNT is legal in any state; retired becomes 0, and clear wins over a simultaneous commit.
- All outputs except commit_en are registered. Command-to-effect latency is one edge.

Decomposition:
- Package exec_ctrl_pkg holds:
  - exec_state_t (HALTED/RUN/STEP)
  - exec_cmd_t (HALT/RUN/STEP_N/CLR_CNT)
  - halt_cause_t (RESET/HOST/BREAKPOINT/HALT_INSTR)
  - localparams for the encodings
- One sub-module is natural: exec_retire_cnt, the CNT_W wrapping counter with synchronous clear and increment inputs.

Test Plan:
- AUTO_RUN=1: release rst, run 5 clocks with no stop conditions -> commit_en=1 each cycle, retired=5, state=RUN.
- AUTO_RUN=0: STEP_N with cmd_count=3 -> exactly 3 commit_en pulses, then halted=1, halt_cause=01, retired=3. A following STEP_N of 0 -> cmd_err pulse, no commit.
- bp_en=1, bp_addr=0x0000000C, RUN with PC advancing by 4 from 0 -> commits at PCs 0, 4, 8; halts with pc=0x0C, cause 10.
  - RUN again -> PC 0x0C commits (bp_skip), execution continues.
- halt_instr asserted at retired=7 while running -> no commit, cause 11. RUN -> one cycle, re-halts, retired still 7.
- HALT and CLR_CNT on consecutive cycles in RUN: HALT cycle has commit_en=0, cause 01; CLR_CNT -> retired=0. STEP_N in RUN -> cmd_err=1 for one cycle.
- Assert rst mid-STEP (remaining=5) -> outputs return to reset values immediately, without waiting for a clock edge.
